// File: rtl/tone_pkg.sv
// Shared types and helpers for the polyphonic tone generator.
package tone_pkg;

  // Per-channel sequencing state.
  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } ch_state_e;

  // Duration tick of 1 ms at a 50 MHz clock.
  localparam int unsigned DefaultTickDiv = 50000;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/poly_tone_gen_if.sv
// Note request handshake: sender drives the note, generator answers with ready.
interface poly_tone_gen_if
  import tone_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 15,
  parameter int unsigned DUR_W  = 12
) ();

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic             note_valid;
  logic             note_ready;
  logic [CH_W-1:0]  note_ch;
  logic [DIV_W-1:0] note_div;
  logic [DUR_W-1:0] note_dur;

  modport master (
    output note_valid,
    output note_ch,
    output note_div,
    output note_dur,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_ch,
    input  note_div,
    input  note_dur,
    output note_ready
  );

endinterface

// File: rtl/tone_channel.sv
// One tone channel: square-wave phase counter, tick prescaler and a
// down-counter shared between note duration and the articulation gap.
module tone_channel
  import tone_pkg::*;
#(
  parameter int unsigned DIV_W     = 15,
  parameter int unsigned DUR_W     = 12,
  parameter int unsigned TICK_DIV  = DefaultTickDiv,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DUR_W-1:0] dur_i,
  output logic             speaker_o,
  output logic             speaker_d_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned PreW = ch_width(TICK_DIV);
  localparam int unsigned GapW = $clog2(GAP_TICKS + 1);
  // The tick counter also holds the gap length, so size it for either use.
  localparam int unsigned CntW = (GapW > DUR_W) ? GapW : DUR_W;
  localparam logic [PreW-1:0] PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_TICKS);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             speaker_q, speaker_d;
  logic             done_q, done_d;
  logic             tick_wrap;
  logic             play_end;

  // Next-state logic: stop overrides everything but reset.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    speaker_d = speaker_q;
    done_d    = 1'b0;
    tick_wrap = (presc_q == PreMax);
    // cnt_q is zero in PLAY only for a zero-length note.
    play_end  = (cnt_q == '0) || (tick_wrap && (cnt_q == CntW'(1)));

    if (stop_i) begin
      state_d   = StIdle;
      speaker_d = 1'b0;
      phase_d   = '0;
      presc_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d   = StPlay;
            div_d     = div_i;
            cnt_d     = CntW'(dur_i);
            phase_d   = '0;
            presc_d   = '0;
            speaker_d = 1'b0;
          end
        end
        StPlay: begin
          if (div_q == '0) begin
            speaker_d = 1'b0;
          end else if (phase_q == div_q) begin
            phase_d   = '0;
            speaker_d = ~speaker_q;
          end else begin
            phase_d = phase_q + 1'b1;
          end
          if (tick_wrap) begin
            presc_d = '0;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (play_end) begin
            speaker_d = 1'b0;
            phase_d   = '0;
            presc_d   = '0;
            if (GAP_TICKS == 0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StGap;
              cnt_d   = GapLoad;
            end
          end
        end
        StGap: begin
          speaker_d = 1'b0;
          if (tick_wrap) begin
            presc_d = '0;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      phase_q   <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      speaker_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      speaker_q <= speaker_d;
      done_q    <= done_d;
    end
  end

  assign speaker_o   = speaker_q;
  assign speaker_d_o = speaker_d;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;

endmodule

// File: rtl/poly_tone_gen.sv
// Multi-channel square-wave tone generator: accept decode, per-channel
// players and a registered popcount of the speaker bits for a DAC.
module poly_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DIV_W     = 15,
  parameter int unsigned DUR_W     = 12,
  parameter int unsigned TICK_DIV  = DefaultTickDiv,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  poly_tone_gen_if.slave               note,
  input  logic [NUM_CH-1:0]            stop,
  output logic [NUM_CH-1:0]            speaker,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic                         bad_ch,
  output logic [$clog2(NUM_CH+1)-1:0]  mix_level
);

  localparam int unsigned CH_W = ch_width(NUM_CH);
  localparam int unsigned MixW = $clog2(NUM_CH + 1);

  logic              in_range;
  logic              ready;
  logic              accept;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] speaker_d;
  logic              bad_ch_q, bad_ch_d;
  logic [MixW-1:0]   mix_q, mix_d;

  // Accept decode; out-of-range requests are always ready so they drain.
  always_comb begin
    in_range = (32'(note.note_ch) < NUM_CH);
    ready    = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (note.note_ch == CH_W'(i)) begin
        ready = ~busy[i];
      end
    end
    accept = note.note_valid & ready;
    start  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      start[i] = accept && (note.note_ch == CH_W'(i));
    end
    bad_ch_d = accept & ~in_range;
  end

  assign note.note_ready = ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_channel #(
      .DIV_W     (DIV_W),
      .DUR_W     (DUR_W),
      .TICK_DIV  (TICK_DIV),
      .GAP_TICKS (GAP_TICKS)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start[i]),
      .stop_i      (stop[i]),
      .div_i       (note.note_div),
      .dur_i       (note.note_dur),
      .speaker_o   (speaker[i]),
      .speaker_d_o (speaker_d[i]),
      .busy_o      (busy[i]),
      .done_o      (done[i])
    );
  end

  // Popcount of next-state speakers so the registered level lines up with speaker.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_d = mix_d + MixW'(speaker_d[i]);
    end
  end

  // Registered bad_ch pulse and mix level.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_ch_q <= 1'b0;
      mix_q    <= '0;
    end else begin
      bad_ch_q <= bad_ch_d;
      mix_q    <= mix_d;
    end
  end

  assign bad_ch    = bad_ch_q;
  assign mix_level = mix_q;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Scoreboard bench for poly_tone_gen: a timing model derived from note
// start cycles predicts every output each cycle.
module tb_poly_tone_gen;
  import tone_pkg::*;

  localparam int NC    = 3;
  localparam int TD    = 4;
  localparam int GAP   = 2;
  localparam int DIV_W = 15;
  localparam int DUR_W = 12;
  localparam int CH_W  = ch_width(NC);
  localparam int MIX_W = $clog2(NC + 1);

  typedef struct {
    logic [NC-1:0]    spk;
    logic [NC-1:0]    busy;
    logic [NC-1:0]    done;
    logic             bad;
    logic [MIX_W-1:0] mix;
    logic             ready;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NC-1:0]    stop;
  logic [NC-1:0]    speaker;
  logic [NC-1:0]    busy;
  logic [NC-1:0]    done;
  logic             bad_ch;
  logic [MIX_W-1:0] mix_level;

  poly_tone_gen_if #(.NUM_CH(NC), .DIV_W(DIV_W), .DUR_W(DUR_W)) nif ();

  poly_tone_gen #(
    .NUM_CH    (NC),
    .DIV_W     (DIV_W),
    .DUR_W     (DUR_W),
    .TICK_DIV  (TD),
    .GAP_TICKS (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .note      (nif),
    .stop      (stop),
    .speaker   (speaker),
    .busy      (busy),
    .done      (done),
    .bad_ch    (bad_ch),
    .mix_level (mix_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb_q[$];
  bit   act[NC];
  int   t0[NC];
  int   m_div[NC];
  int   m_dur[NC];
  bit   bad_pend;
  bit   last_acc;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   max_mix;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int play_len(input int ch);
    return (m_dur[ch] == 0) ? 1 : m_dur[ch] * TD;
  endfunction

  function automatic int note_len(input int ch);
    return play_len(ch) + GAP * TD;
  endfunction

  // Expected outputs of one channel k cycles after its accept edge.
  function automatic void exp_ch(input int ch, output logic s, output logic b, output logic d);
    int k;
    s = 1'b0;
    b = 1'b0;
    d = 1'b0;
    if (act[ch]) begin
      k = cyc - t0[ch];
      if (k <= play_len(ch)) begin
        b = 1'b1;
        s = (m_div[ch] != 0) && ((((k - 1) / (m_div[ch] + 1)) % 2) == 1);
      end else if (k <= note_len(ch)) begin
        b = 1'b1;
      end else if (k == note_len(ch) + 1) begin
        d = 1'b1;
      end
    end
  endfunction

  // One clock cycle: predict, compare at negedge, advance the model at the edge.
  task automatic step();
    exp_t e;
    logic s, b, d;
    int   ch;
    e.spk  = '0;
    e.busy = '0;
    e.done = '0;
    e.mix  = '0;
    for (int i = 0; i < NC; i++) begin
      exp_ch(i, s, b, d);
      e.spk[i]  = s;
      e.busy[i] = b;
      e.done[i] = d;
      e.mix     = e.mix + MIX_W'(s);
    end
    ch      = int'(nif.note_ch);
    e.ready = (ch < NC) ? ~e.busy[ch] : 1'b1;
    e.bad   = bad_pend;
    sb_q.push_back(e);

    @(negedge clk);
    e = sb_q.pop_front();
    check_eq("speaker", 32'(speaker), 32'(e.spk));
    check_eq("busy", 32'(busy), 32'(e.busy));
    check_eq("done", 32'(done), 32'(e.done));
    check_eq("bad_ch", 32'(bad_ch), 32'(e.bad));
    check_eq("mix_level", 32'(mix_level), 32'(e.mix));
    check_eq("note_ready", 32'(nif.note_ready), 32'(e.ready));
    if (int'(mix_level) > max_mix) max_mix = int'(mix_level);

    last_acc = nif.note_valid && e.ready;
    if (reset) begin
      for (int i = 0; i < NC; i++) act[i] = 1'b0;
      bad_pend = 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (act[i] && (cyc - t0[i] >= note_len(i) + 1)) act[i] = 1'b0;
        if (stop[i]) act[i] = 1'b0;
      end
      bad_pend = last_acc && (ch >= NC);
      if (last_acc && (ch < NC) && !stop[ch]) begin
        act[ch]   = 1'b1;
        t0[ch]    = cyc;
        m_div[ch] = int'(nif.note_div);
        m_dur[ch] = int'(nif.note_dur);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a note and hold it until the model says it was taken.
  task automatic drive_note(input int ch, input int dv, input int du);
    int n;
    n = 0;
    nif.note_valid = 1'b1;
    nif.note_ch    = CH_W'(ch);
    nif.note_div   = DIV_W'(dv);
    nif.note_dur   = DUR_W'(du);
    last_acc       = 1'b0;
    while (!last_acc && n < 200) begin
      step();
      n++;
    end
    check_eq("accepted", 32'(last_acc), 32'd1);
    nif.note_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    max_mix  = 0;
    bad_pend = 1'b0;
    last_acc = 1'b0;
    cyc      = 0;
    for (int i = 0; i < NC; i++) begin
      act[i]   = 1'b0;
      t0[i]    = 0;
      m_div[i] = 0;
      m_dur[i] = 0;
    end
    reset          = 1'b1;
    stop           = '0;
    nif.note_valid = 1'b0;
    nif.note_ch    = '0;
    nif.note_div   = '0;
    nif.note_dur   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Basic tone with gap, then a rest note, then a zero-length note.
    drive_note(0, 3, 5);
    idle(32);
    drive_note(0, 0, 3);
    idle(24);
    drive_note(0, 2, 0);
    idle(12);

    // Two channels started back to back; their speakers overlap.
    max_mix = 0;
    drive_note(0, 1, 4);
    drive_note(1, 2, 4);
    idle(30);
    check_eq("mix_peak", 32'(max_mix), 32'd2);

    // Held request for a busy channel is taken in its done cycle.
    drive_note(0, 2, 2);
    drive_note(0, 1, 1);
    idle(20);

    // Stop mid-play, then stop together with an accept.
    drive_note(0, 3, 5);
    idle(6);
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    idle(3);
    stop[0] = 1'b1;
    drive_note(0, 3, 2);
    stop[0] = 1'b0;
    idle(5);

    // Out-of-range channel, alone and while another channel plays.
    drive_note(3, 5, 5);
    idle(3);
    drive_note(1, 2, 6);
    idle(2);
    drive_note(3, 1, 1);
    idle(4);

    // Reset in the middle of a note.
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
